// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Shares the single cache request port between two CPU-side requesters using
// round-robin arbitration. The winning request is registered onto the cache
// inputs and held until the cache reports hit. The read data and a one-cycle
// done strobe then go back to the winner.
//
// Parameters:
//   TIMEOUT      maximum BUSY cycles without hit before abort (watchdog only)
//
// Ports:
//   clock, reset               clock and synchronous active-high reset
//   read0/write0/addr0/wdata0  requester 0 operation, address, write data
//   read1/write1/addr1/wdata1  requester 1 operation, address, write data
//   done0/done1                one-cycle completion strobe per requester
//   rdata0/rdata1              read return data (held after done)
//   err0/err1                  abort flag, qualified by done
//   read/write/Address/Write_Data  request to the cache
//   hit/rData                  completion and read data from the cache
//   busy                       high while an access is in flight (BUSY/RESP)
//
// Optional feature: define CACHE_ARB_WATCHDOG_EN to abort an access that
// sees no hit within TIMEOUT BUSY cycles (reported with err).
//
// MEM_ADDR_SIZE / WORD_SIZE_BIT normally come from sys_defs.vh; fallback
// values are provided so the block builds on its own.
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 8
`endif
`ifndef WORD_SIZE_BIT
`define WORD_SIZE_BIT 16
`endif

module cache_req_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      read0,
    input  logic                      write0,
    input  logic [`MEM_ADDR_SIZE-1:0] addr0,
    input  logic [`WORD_SIZE_BIT-1:0] wdata0,
    input  logic                      read1,
    input  logic                      write1,
    input  logic [`MEM_ADDR_SIZE-1:0] addr1,
    input  logic [`WORD_SIZE_BIT-1:0] wdata1,
    output logic                      done0,
    output logic                      done1,
    output logic [`WORD_SIZE_BIT-1:0] rdata0,
    output logic [`WORD_SIZE_BIT-1:0] rdata1,
    output logic                      err0,
    output logic                      err1,
    output logic                      read,
    output logic                      write,
    output logic [`MEM_ADDR_SIZE-1:0] Address,
    output logic [`WORD_SIZE_BIT-1:0] Write_Data,
    input  logic                      hit,
    input  logic [`WORD_SIZE_BIT-1:0] rData,
    output logic                      busy
);

    localparam int AW = `MEM_ADDR_SIZE;
    localparam int DW = `WORD_SIZE_BIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Per-requester views of the request inputs.
    logic [1:0]    rd_req;
    logic [1:0]    wr_req;
    logic [1:0]    any_req;
    logic [AW-1:0] addr_req  [2];
    logic [DW-1:0] wdata_req [2];

    assign rd_req = {read1, read0};
    assign wr_req = {write1, write0};
    assign addr_req[0]  = addr0;
    assign addr_req[1]  = addr1;
    assign wdata_req[0] = wdata0;
    assign wdata_req[1] = wdata1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign any_req[gi] = rd_req[gi] | wr_req[gi];
        end
    endgenerate

    state_t        state_reg, state_next;
    logic          last_grant_reg, last_grant_next;
    logic          grant_reg, grant_next;
    logic          read_reg, read_next;
    logic          write_reg, write_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [1:0]    done_reg, done_next;
    logic [1:0]    err_reg, err_next;
    logic [DW-1:0] rdata_reg [2];
    logic [DW-1:0] rdata_next [2];
    logic          winner;

`ifdef CACHE_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
`endif

    // Under contention the requester that did not win last time goes first;
    // a lone requester wins outright.
    assign winner = (any_req == 2'b11) ? ~last_grant_reg : any_req[1];

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
`ifdef CACHE_ARB_WATCHDOG_EN
        wd_cnt_next     = wd_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|any_req) begin
                    grant_next      = winner;
                    last_grant_next = winner;
                    // Read+write together is a write; read stays low.
                    write_next      = wr_req[winner];
                    read_next       = rd_req[winner] & ~wr_req[winner];
                    addr_next       = addr_req[winner];
                    wdata_next      = wdata_req[winner];
                    state_next      = BUSY;
`ifdef CACHE_ARB_WATCHDOG_EN
                    wd_cnt_next     = '0;
`endif
                end
            end
            BUSY: begin
                if (hit) begin
                    if (read_reg) begin
                        rdata_next[grant_reg] = rData;
                    end
                    done_next[grant_reg] = 1'b1;
                    read_next            = 1'b0;
                    write_next           = 1'b0;
                    state_next           = RESP;
                end
`ifdef CACHE_ARB_WATCHDOG_EN
                else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    done_next[grant_reg] = 1'b1;
                    err_next[grant_reg]  = 1'b1;
                    read_next            = 1'b0;
                    write_next           = 1'b0;
                    state_next           = RESP;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
`endif
            end
            RESP: begin
                // Single response cycle; no arbitration here.
                done_next  = '0;
                err_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            done_reg       <= '0;
            err_reg        <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
`ifdef CACHE_ARB_WATCHDOG_EN
            wd_cnt_reg     <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            rdata_reg[0]   <= rdata_next[0];
            rdata_reg[1]   <= rdata_next[1];
`ifdef CACHE_ARB_WATCHDOG_EN
            wd_cnt_reg     <= wd_cnt_next;
`endif
        end
    end

    assign read       = read_reg;
    assign write      = write_reg;
    assign Address    = addr_reg;
    assign Write_Data = wdata_reg;
    assign done0      = done_reg[0];
    assign done1      = done_reg[1];
    assign err0       = err_reg[0];
    assign err1       = err_reg[1];
    assign rdata0     = rdata_reg[0];
    assign rdata1     = rdata_reg[1];
    assign busy       = (state_reg != IDLE);

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Two-port round-robin arbiter that shares the single cache request port between two CPU-side requesters. It registers the winning request onto the cache's `read`/`write`/`Address`/`Write_Data` inputs and holds it until the cache asserts `hit`. It then returns `rData` and a one-cycle `done` strobe to the winner. It sits between the CPU-side request generators and the cache, in place of a direct CPU-to-cache connection.

## Interface

Parameters:
- `TIMEOUT`, default 64: maximum BUSY cycles without `hit` before abort (used only with the watchdog).

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `read0`, `write0` in 1 each: requester 0 operation.
- `addr0` in `MEM_ADDR_SIZE`: requester 0 address.
- `wdata0` in `WORD_SIZE_BIT`: requester 0 write data.
- `read1`, `write1`, `addr1`, `wdata1`: same as requester 0, for requester 1.
- `done0`, `done1` out 1: one-cycle completion strobe.
- `rdata0`, `rdata1` out `WORD_SIZE_BIT`: read return data, valid while `done` is high and held afterwards.
- `err0`, `err1` out 1: abort flag, qualified by `done`.
- `read`, `write` out 1: to cache.
- `Address` out `MEM_ADDR_SIZE`: to cache.
- `Write_Data` out `WORD_SIZE_BIT`: to cache.
- `hit` in 1: from cache; completion of the current access.
- `rData` in `WORD_SIZE_BIT`: from cache.
- `busy` out 1: high in BUSY and RESP.

Width macros come from `sys_defs.vh`.

## Operation

- A requester's request is `readN | writeN`. If both are set, it is treated as a write: `read` to the cache stays 0.
- A requester holds its request stable until it sees its `done`.
- States:
  - **IDLE**
    - No request: stay in IDLE.
    - Requests present: pick a winner, latch its op, address and data into the cache-side output registers, record it in `grant`, and go to BUSY.
  - **BUSY**
    - `read`/`write` to the cache are held constant.
    - On an edge where `hit`=1: capture `rData` into the winner's `rdata` (reads only; writes leave `rdata` unchanged), set the winner's `done`, clear `read`/`write`, and go to RESP.
  - **RESP**
    - Lasts exactly one cycle, with `done` high.
    - No arbitration happens in this cycle, so a request still asserted here is not re-granted.
    - Clear `done` and `err`, then go to IDLE.
- Round-robin arbitration:
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - When both request in IDLE, the winner is `~last_grant`.
  - When one requests, it wins regardless of `last_grant`.
  - `last_grant` updates on every grant.
- `Address`/`Write_Data` keep their last values in IDLE; only `read`/`write` qualify them.
- Reset values: state IDLE, `last_grant`=1, and all outputs 0 (`read`, `write`, `Address`, `Write_Data`, `done0/1`, `rdata0/1`, `err0/1`, `busy`).
- Reset mid-access: the access is abandoned with no `done`; the cache sees `read`/`write` drop in the cycle after the reset edge.

## Timing

- Request visible in IDLE at edge N → cache `read`/`write` asserted from N+1.
- `hit` sampled at edge M in BUSY → `done` high in cycle M+1 (RESP) → IDLE from M+2.
- Earliest re-grant is at edge M+2; minimum issue interval is 3 cycles per access when `hit` arrives on the first BUSY edge.
- A `hit` while in IDLE or RESP is ignored.
- With both requesters continuously requesting, grants alternate 0,1,0,1.

## Configuration

Macro `CACHE_ARB_WATCHDOG_EN`.

- **Defined:**
  - A `$clog2(TIMEOUT)+1`-bit counter clears on entry to BUSY and increments on each BUSY edge without `hit`.
  - On the edge where the count equals `TIMEOUT-1` and `hit`=0: abort to RESP with the winner's `done`=1 and `err`=1; `rdata` is unchanged and `read`/`write` are cleared.
  - `hit` on that same edge wins: normal completion, `err`=0.
- **Not defined:** no counter; BUSY waits indefinitely; `err0`/`err1` are tied 0.

## Test plan

- **Single read.** After reset, requester 0 reads `8'b11011100` and the cache returns `hit` on the 3rd BUSY edge with `rData`=151.
  - `read`=1 and `Address`=`8'hDC` from the cycle after the request.
  - `done0`=1 and `rdata0`=151 for exactly one cycle; `done1` stays 0.
- **Write with both bits set.** Requester 1 sets `read1`=1, `write1`=1, `addr1`=`8'h5C`, `wdata1`=758.
  - Cache sees `write`=1, `read`=0, `Write_Data`=758.
  - `done1` pulses after `hit`; `rdata1` is unchanged.
- **Contention.** Both requesters request continuously from reset, with `hit` on the first BUSY edge each time.
  - Grant order is 0,1,0,1.
  - `done` pulses are spaced exactly 3 cycles apart.
- **Hit outside BUSY.** `hit` held high while in IDLE and in RESP → no state change and no extra `done`.
- **Reset mid-access.** Reset asserted during BUSY → all outputs 0 in the following cycle, no `done`, and requester 0 wins the next contention.
- **Watchdog abort (`CACHE_ARB_WATCHDOG_EN`, `TIMEOUT`=8).** `hit` never asserted → `done0`=1 and `err0`=1 in the cycle after the 8th BUSY edge, `read` drops; without the macro the arbiter remains in BUSY.
